// File: rtl/floo_vc_input_buffer.sv
// Per-VC input buffer for a FlooNoC VC router port: one circular FIFO per VC, heads to the allocator, one credit per pop.
// Optional combinational empty-VC bypass is enabled by defining FLOO_VC_IN_BYPASS_EN.
module floo_vc_input_buffer #(
    parameter int NumVC     = 4,
    parameter int VcIdWidth = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int Depth     = 2,
    parameter int DataWidth = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               data_v_i,
    input  logic [DataWidth-1:0]               data_i,
    input  logic [VcIdWidth-1:0]               vc_id_i,
    output logic                               credit_v_o,
    output logic [VcIdWidth-1:0]               credit_id_o,
    output logic [NumVC-1:0]                   head_v_o,
    output logic [NumVC*DataWidth-1:0]         head_data_o,
    input  logic                               pop_v_i,
    input  logic [VcIdWidth-1:0]               pop_vc_i,
    output logic [NumVC*$clog2(Depth+1)-1:0]   occupancy_o,
    output logic [2:0]                         err_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    // Flow control is valid-only: data_v_i carries no ready, the upstream router
    // only sends when it holds a credit, and credit_v_o returns one credit per pop.

    logic [DataWidth-1:0] mem    [NumVC][Depth];
    logic [PtrW-1:0]      rd_ptr [NumVC];
    logic [PtrW-1:0]      wr_ptr [NumVC];
    logic [CntW-1:0]      count  [NumVC];

    logic                 push_id_ok;
    logic                 pop_id_ok;
    logic                 bad_id;
    logic [NumVC-1:0]     push_hit;
    logic [NumVC-1:0]     pop_hit;
    logic [NumVC-1:0]     empty;
    logic [NumVC-1:0]     full;
    logic [NumVC-1:0]     bypass;
    logic [NumVC-1:0]     byp_head;
    logic [NumVC-1:0]     pop_mem;
    logic [NumVC-1:0]     push_do;
    logic [NumVC-1:0]     credit_pop;
    logic [NumVC-1:0]     overflow;
    logic [NumVC-1:0]     underflow;

    logic                 credit_v_q;
    logic [VcIdWidth-1:0] credit_id_q;
    logic [2:0]           err_q;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign push_id_ok = int'(vc_id_i) < NumVC;
    assign pop_id_ok  = int'(pop_vc_i) < NumVC;
    assign bad_id     = (data_v_i && !push_id_ok) || (pop_v_i && !pop_id_ok);

    always_comb begin
        push_hit   = '0;
        pop_hit    = '0;
        empty      = '0;
        full       = '0;
        bypass     = '0;
        byp_head   = '0;
        pop_mem    = '0;
        push_do    = '0;
        credit_pop = '0;
        overflow   = '0;
        underflow  = '0;
        for (int v = 0; v < NumVC; v++) begin
            push_hit[v] = data_v_i && (vc_id_i == VcIdWidth'(v));
            pop_hit[v]  = pop_v_i && (pop_vc_i == VcIdWidth'(v));
            empty[v]    = (count[v] == '0);
            full[v]     = (count[v] == FullCnt);
`ifdef FLOO_VC_IN_BYPASS_EN
            // An arriving flit on an empty VC is visible at once and may leave without being stored.
            byp_head[v] = empty[v] && push_hit[v] && !rst_n;
            bypass[v]   = byp_head[v] && pop_hit[v];
`else
            byp_head[v] = 1'b0;
            bypass[v]   = 1'b0;
`endif
            pop_mem[v]    = pop_hit[v] && !empty[v];
            credit_pop[v] = pop_mem[v] || bypass[v];
            // A full VC still accepts a flit when its head leaves in the same cycle.
            push_do[v]    = push_hit[v] && (!full[v] || pop_mem[v]) && !bypass[v];
            overflow[v]   = push_hit[v] && full[v] && !pop_mem[v];
            underflow[v]  = pop_hit[v] && empty[v] && !bypass[v];
        end
    end

    always_comb begin
        head_v_o    = '0;
        head_data_o = '0;
        occupancy_o = '0;
        for (int v = 0; v < NumVC; v++) begin
            head_v_o[v] = !empty[v] || byp_head[v];
            if (!empty[v]) begin
                head_data_o[v*DataWidth +: DataWidth] = mem[v][rd_ptr[v]];
            end else if (byp_head[v]) begin
                head_data_o[v*DataWidth +: DataWidth] = data_i;
            end
            occupancy_o[v*CntW +: CntW] = count[v];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int v = 0; v < NumVC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
            credit_v_q  <= 1'b0;
            credit_id_q <= '0;
            err_q       <= '0;
        end else begin
            for (int v = 0; v < NumVC; v++) begin
                if (push_do[v]) begin
                    wr_ptr[v] <= next_ptr(wr_ptr[v]);
                end
                if (pop_mem[v]) begin
                    rd_ptr[v] <= next_ptr(rd_ptr[v]);
                end
                case ({push_do[v], pop_mem[v]})
                    2'b10:   count[v] <= count[v] + CntW'(1);
                    2'b01:   count[v] <= count[v] - CntW'(1);
                    default: count[v] <= count[v];
                endcase
            end
            credit_v_q  <= |credit_pop;
            credit_id_q <= (|credit_pop) ? pop_vc_i : '0;
            err_q       <= err_q | {bad_id, |underflow, |overflow};
        end
    end

    // Flit storage is not reset: a slot is only observable after it has been written.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NumVC; v++) begin
            if (push_do[v]) begin
                mem[v][wr_ptr[v]] <= data_i;
            end
        end
    end

    assign credit_v_o  = credit_v_q;
    assign credit_id_o = credit_id_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_floo_vc_input_buffer.sv
// Bench for floo_vc_input_buffer: per-VC queue model, directed test-plan sequences, then randomized traffic.
module tb_floo_vc_input_buffer;

    localparam int NV = 4;
    localparam int DP = 2;
    localparam int DW = 64;
    localparam int IW = 3;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              data_v_i;
    logic [DW-1:0]     data_i;
    logic [IW-1:0]     vc_id_i;
    logic              credit_v_o;
    logic [IW-1:0]     credit_id_o;
    logic [NV-1:0]     head_v_o;
    logic [NV*DW-1:0]  head_data_o;
    logic              pop_v_i;
    logic [IW-1:0]     pop_vc_i;
    logic [NV*CW-1:0]  occupancy_o;
    logic [2:0]        err_o;

    always #5 clk = ~clk;

    floo_vc_input_buffer #(
        .NumVC(NV), .VcIdWidth(IW), .Depth(DP), .DataWidth(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_v_i(data_v_i), .data_i(data_i), .vc_id_i(vc_id_i),
        .credit_v_o(credit_v_o), .credit_id_o(credit_id_o),
        .head_v_o(head_v_o), .head_data_o(head_data_o),
        .pop_v_i(pop_v_i), .pop_vc_i(pop_vc_i),
        .occupancy_o(occupancy_o), .err_o(err_o)
    );

    // Reference model: one plain queue per VC plus the expected registered outputs.
    typedef logic [DW-1:0] flit_q_t[$];
    flit_q_t       exp_q [NV];
    logic          exp_cv = 1'b0;
    logic [IW-1:0] exp_cid = '0;
    logic [2:0]    exp_err = '0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) exp_q[i].delete();
        exp_cv  = 1'b0;
        exp_cid = '0;
        exp_err = '0;
    endtask

    task automatic model_step(input logic dv, input logic [DW-1:0] d, input logic [IW-1:0] vc,
                              input logic pv, input logic [IW-1:0] pvc);
        int  pre [NV];
        int  wv;
        int  pq;
        bit  popped;
        bit  consumed;
        popped   = 0;
        consumed = 0;
        wv = int'(vc);
        pq = int'(pvc);
        if (rst_n) begin
            model_clear();
            return;
        end
        for (int i = 0; i < NV; i++) pre[i] = exp_q[i].size();
        if (dv && wv >= NV) exp_err[2] = 1'b1;
        if (pv && pq >= NV) exp_err[2] = 1'b1;
        if (pv && pq < NV) begin
            if (pre[pq] > 0) begin
                void'(exp_q[pq].pop_front());
                popped = 1;
            end
`ifdef FLOO_VC_IN_BYPASS_EN
            else if (dv && wv == pq) begin
                popped   = 1;
                consumed = 1;
            end
`endif
            else exp_err[1] = 1'b1;
        end
        if (dv && wv < NV && !consumed) begin
            if (pre[wv] < DP || (popped && pq == wv)) exp_q[wv].push_back(d);
            else exp_err[0] = 1'b1;
        end
        exp_cv  = popped;
        exp_cid = popped ? pvc : '0;
    endtask

    task automatic compare_all();
        logic [NV-1:0]    ehv;
        logic [NV*DW-1:0] ehd;
        logic [NV*CW-1:0] eocc;
        int sz;
        ehv  = '0;
        ehd  = '0;
        eocc = '0;
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) begin
                sz = exp_q[i].size();
                eocc[i*CW +: CW] = CW'(sz);
                if (sz > 0) begin
                    ehv[i] = 1'b1;
                    ehd[i*DW +: DW] = exp_q[i][0];
                end
`ifdef FLOO_VC_IN_BYPASS_EN
                else if (data_v_i && int'(vc_id_i) == i) begin
                    ehv[i] = 1'b1;
                    ehd[i*DW +: DW] = data_i;
                end
`endif
            end
        end
        check("head_v", head_v_o, ehv);
        check("head_data", head_data_o, ehd);
        check("occupancy", occupancy_o, eocc);
        check("credit_v", credit_v_o, exp_cv);
        check("credit_id", credit_id_o, exp_cid);
        check("err", err_o, exp_err);
    endtask

    task automatic drive(input logic dv, input logic [DW-1:0] d, input logic [IW-1:0] vc,
                         input logic pv, input logic [IW-1:0] pvc);
        data_v_i = dv;
        data_i   = d;
        vc_id_i  = vc;
        pop_v_i  = pv;
        pop_vc_i = pvc;
    endtask

    // One clock: drive at the falling edge, compare 1 ns later, advance the model at the rising edge.
    task automatic cycle(input logic dv, input logic [DW-1:0] d, input logic [IW-1:0] vc,
                         input logic pv, input logic [IW-1:0] pvc);
        drive(dv, d, vc, pv, pvc);
        #1;
        compare_all();
        @(posedge clk);
        model_step(dv, d, vc, pv, pvc);
        @(negedge clk);
    endtask

    task automatic idle_now();
        drive(1'b0, '0, '0, 1'b0, '0);
        #1;
    endtask

    task automatic reset_pulse();
        drive(1'b0, '0, '0, 1'b0, '0);
        rst_n = 1'b1;
        model_clear();
        #1;
        compare_all();
        check("rst_head_v", head_v_o, 0);
        check("rst_head_data", head_data_o, 0);
        check("rst_occ", occupancy_o, 0);
        check("rst_credit", {credit_v_o, credit_id_o}, 0);
        check("rst_err", err_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    localparam logic [DW-1:0] FA = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [DW-1:0] FB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [DW-1:0] FC = 64'hC0C0_C0C0_C0C0_C0C0;
    localparam logic [DW-1:0] FD = 64'hD00D_D00D_D00D_D00D;
    localparam logic [DW-1:0] FE = 64'hE1E2_E3E4_E5E6_E7E8;

    initial begin
        logic          dv, pv;
        logic [IW-1:0] vc, pvc;
        logic [DW-1:0] d;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        reset_pulse();

        // Single flit through VC1.
        cycle(1'b1, FA, 3'd1, 1'b0, 3'd0);
        idle_now();
        check("t1_head_v", head_v_o, 4'b0010);
        check("t1_head1", head_data_o[1*DW +: DW], FA);
        check("t1_occ1", occupancy_o[1*CW +: CW], 1);
        cycle(1'b0, '0, 3'd0, 1'b1, 3'd1);
        idle_now();
        check("t2_credit", {credit_v_o, credit_id_o}, {1'b1, 3'd1});
        check("t2_head_v", head_v_o, 0);

        // Overflow on VC2, then full push+pop, then drain.
        cycle(1'b1, FA, 3'd2, 1'b0, 3'd0);
        cycle(1'b1, FB, 3'd2, 1'b0, 3'd0);
        cycle(1'b1, FC, 3'd2, 1'b0, 3'd0);
        idle_now();
        check("ovf_err", err_o, 3'b001);
        check("ovf_occ2", occupancy_o[2*CW +: CW], 2);
        check("ovf_head2", head_data_o[2*DW +: DW], FA);
        cycle(1'b1, FD, 3'd2, 1'b1, 3'd2);
        idle_now();
        check("fullpp_err", err_o, 3'b001);
        check("fullpp_occ2", occupancy_o[2*CW +: CW], 2);
        check("fullpp_head2", head_data_o[2*DW +: DW], FB);
        check("fullpp_credit", {credit_v_o, credit_id_o}, {1'b1, 3'd2});
        cycle(1'b0, '0, 3'd0, 1'b1, 3'd2);
        idle_now();
        check("drain_head2", head_data_o[2*DW +: DW], FD);
        check("drain_credit", {credit_v_o, credit_id_o}, {1'b1, 3'd2});
        cycle(1'b0, '0, 3'd0, 1'b1, 3'd2);
        idle_now();
        check("drain_empty", head_v_o, 0);

        // Underflow and bad VC id.
        cycle(1'b0, '0, 3'd0, 1'b1, 3'd0);
        idle_now();
        check("unf_credit", credit_v_o, 0);
        check("unf_err1", err_o[1], 1);
        cycle(1'b1, FE, 3'd5, 1'b0, 3'd0);
        idle_now();
        check("bad_err2", err_o[2], 1);
        check("bad_occ", occupancy_o, 0);

        // Empty-VC push with same-cycle pop.
        reset_pulse();
        drive(1'b1, FE, 3'd0, 1'b1, 3'd0);
        #1;
        compare_all();
`ifdef FLOO_VC_IN_BYPASS_EN
        check("byp_head_v0", head_v_o[0], 1);
        check("byp_head0", head_data_o[0*DW +: DW], FE);
`endif
        @(posedge clk);
        model_step(1'b1, FE, 3'd0, 1'b1, 3'd0);
        @(negedge clk);
        idle_now();
`ifdef FLOO_VC_IN_BYPASS_EN
        check("byp_credit", {credit_v_o, credit_id_o}, {1'b1, 3'd0});
        check("byp_occ0", occupancy_o[0*CW +: CW], 0);
        check("byp_err", err_o, 0);
`else
        check("nobyp_credit", credit_v_o, 0);
        check("nobyp_err", err_o, 3'b010);
        check("nobyp_occ0", occupancy_o[0*CW +: CW], 1);
`endif

        // Interleaved VC0/VC3 pushes with a VC3 pop every cycle.
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom};
            cycle(1'b1, d, (i % 2 == 0) ? 3'd3 : 3'd0, 1'b1, 3'd3);
        end
        cycle(1'b0, '0, 3'd0, 1'b0, 3'd0);

        // Mid-stream reset with stored flits.
        cycle(1'b1, FA, 3'd1, 1'b0, 3'd0);
        cycle(1'b1, FB, 3'd2, 1'b1, 3'd1);
        reset_pulse();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            dv  = ($urandom_range(0, 9) < 6);
            vc  = ($urandom_range(0, 19) == 0) ? IW'($urandom_range(4, 7)) : IW'($urandom_range(0, 3));
            pv  = ($urandom_range(0, 9) < 5);
            pvc = ($urandom_range(0, 19) == 0) ? IW'($urandom_range(4, 7)) : IW'($urandom_range(0, 3));
            d   = {$urandom, $urandom};
            cycle(dv, d, vc, pv, pvc);
            if ($urandom_range(0, 299) == 0) reset_pulse();
        end

        idle_now();
        compare_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/floo_vc_input_buffer.md
Name: floo_vc_input_buffer

Overview:
- Parametrised per-virtual-channel input buffer for the FlooNoC VC router input port.
- Accepts flits tagged with a VC id and stores each in that VC's private FIFO.
- Presents every VC head to the switch allocator, which pops them.
- Returns one credit per popped flit to the upstream router, so upstream credit counters track free slots per VC.

Parameters:
- NumVC, 4, number of virtual channels (>=1).
- VcIdWidth, $clog2(NumVC) (min 1), width of VC id fields.
- Depth, 2, flit slots per VC (>=1, need not be a power of two).
- DataWidth, 64, flit width in bits (whole flit incl. header; opaque to this block).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- data_v_i  in  1  incoming flit valid (no ready; credit-based flow control).
- data_i  in  DataWidth  incoming flit.
- vc_id_i  in  VcIdWidth  target VC of incoming flit.
- credit_v_o  out  1  credit return valid to upstream.
- credit_id_o  out  VcIdWidth  VC whose slot was freed.
- head_v_o  out  NumVC  per-VC head flit valid (VC non-empty).
- head_data_o  out  NumVC*DataWidth  per-VC head flit.
- pop_v_i  in  1  allocator pops one flit this cycle.
- pop_vc_i  in  VcIdWidth  VC to pop.
- occupancy_o  out  NumVC*$clog2(Depth+1)  per-VC fill level.
- err_o  out  3  sticky errors: [0] overflow, [1] underflow, [2] bad VC id.

Behaviour:
- Reset is asynchronous, active when rst_n=1. While in reset:
  - all FIFO pointers and counts are 0.
  - head_v_o=0, head_data_o=0, occupancy_o=0.
  - credit_v_o=0, credit_id_o=0, err_o=0.
- Reset asserted mid-operation discards all stored flits and drops any pending credit, with no credit emitted.
- Each VC is an independent circular FIFO with read pointer, write pointer and count.
  - Pointers wrap from Depth-1 to 0.
  - count ranges 0..Depth.
- Push: data_v_i=1 with vc_id_i=v<NumVC writes data_i at the write pointer of VC v on the clock edge.
  - head_v_o[v] and occupancy_o reflect the push in the next cycle (latency 1).
- Pop: pop_v_i=1 with pop_vc_i=v advances the read pointer and decrements count of VC v at the edge.
  - head_data_o[v] is combinational from the read pointer.
- Credit: every successful pop at cycle t gives credit_v_o=1, credit_id_o=v in cycle t+1 (registered).
  - At most one credit per cycle.
  - credit_id_o=0 when credit_v_o=0.
- Simultaneous push and pop, same VC: both take effect and count is unchanged.
  - This also applies when the VC is full.
  - A push into an empty VC cannot be popped in the same cycle: the pop is an underflow.
- Simultaneous push and pop, different VCs: fully independent.
- Overflow: push to a full VC without a same-VC pop.
  - The flit is dropped, state is unchanged, and err_o[0] is set.
- Underflow: pop of a VC with count=0.
  - Ignored, no credit, err_o[1] is set.
- Bad id:
  - vc_id_i>=NumVC with data_v_i=1: flit dropped, err_o[2] set.
  - pop_vc_i>=NumVC with pop_v_i=1: ignored, err_o[2] set.
- err_o bits clear only on reset.
- Stored flits are never modified; FIFO order is preserved per VC.

Optional Feature:
- Macro: FLOO_VC_IN_BYPASS_EN.
- When defined and VC v has count=0 with data_v_i=1, vc_id_i=v:
  - head_v_o[v]=1 and head_data_o[v]=data_i in the same cycle (combinational bypass).
  - If that VC is popped in the same cycle, the flit is not written, count stays 0, and the credit is still returned in t+1 (no underflow).
  - If it is not popped, the flit is written normally.
- When undefined: latency 1 as above, and a same-cycle pop of an empty VC is an underflow.

Test Plan:
- Reset release, NumVC=4, Depth=2:
  - Push flit A (0xA5..) to VC1 at t0 -> head_v_o=4'b0010 and head_data_o[1]=A at t1, occupancy[1]=1.
  - Pop VC1 at t1 -> credit_v_o=1, credit_id_o=1 at t2, head_v_o=0.
- Push A,B to VC2, then a third flit C to VC2:
  - err_o[0]=1, occupancy[2]=2.
  - Pops return A then B with credits 2,2, and C never appears.
- VC2 full; push D and pop VC2 in the same cycle:
  - no error, occupancy stays 2.
  - Next pops return B then D (after A was popped).
- Interleave pushes to VC0/VC3 with pops of VC3 every cycle for 8 cycles:
  - per-VC order preserved, pointers wrap correctly (also with Depth=3).
  - Exactly one credit with id 3 per pop.
- Pop empty VC0 -> no credit, err_o[1]=1.
  - push with vc_id_i=5 at NumVC=4 (VcIdWidth=3) -> dropped, err_o[2]=1.
  - Assert rst_n mid-stream -> all outputs 0 immediately.
- With FLOO_VC_IN_BYPASS_EN: push E to empty VC0 with pop VC0 in the same cycle:
  - head_data_o[0]=E combinationally that cycle.
  - credit id 0 next cycle, occupancy[0]=0, err_o=0.
